pixel_histogram_engine: RTL and testbench

- Computes a 64-bin intensity histogram of a 4096-pixel, 6-bit grayscale image held in an internal, externally loadable image memory.
- A 12-bit address counter walks every pixel.
- A pixel selector fetches each pixel value.
- A read-modify-write pass increments the matching bin in histogram RAM.
- Used as the feature-extraction front end ahead of the decision-tree classifier.

---
 rtl/pixel_hist_pkg.sv | 25 ++
 rtl/hist_bin_ram.sv | 40 ++++
 rtl/pixel_histogram_engine.sv | 155 +++++++++++++++
 tb/tb_pixel_histogram_engine.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pixel_hist_pkg.sv
// Shared constants, FSM state encoding and bin-write payload for the pixel histogram engine.
package pixel_hist_pkg;

    localparam int unsigned PIX_W      = 6;
    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned N_PIX      = 2 ** ADDR_W;
    localparam int unsigned N_BINS     = 2 ** PIX_W;
    localparam int unsigned BIN_W      = ADDR_W + 1;
    localparam int unsigned PIPE_DEPTH = 3;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SCAN,
        DRAIN,
        DONE
    } state_e;

    typedef struct packed {
        logic             we;
        logic [PIX_W-1:0] addr;
        logic [BIN_W-1:0] data;
    } bin_wr_t;

endpackage

// File: rtl/hist_bin_ram.sv
// 64 x 13 histogram RAM: port A accumulates (read + write), port B is a read-only readout.
module hist_bin_ram
    import pixel_hist_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  bin_wr_t          a_wr_i,
    input  logic [PIX_W-1:0] a_raddr_i,
    output logic [BIN_W-1:0] a_rdata_o,
    input  logic             b_en_i,
    input  logic [PIX_W-1:0] b_raddr_i,
    output logic [BIN_W-1:0] b_rdata_o
);

    logic [BIN_W-1:0] mem_q [N_BINS];
    logic [BIN_W-1:0] a_rdata_q;
    logic [BIN_W-1:0] b_rdata_q;

    // Array contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (a_wr_i.we) begin
            mem_q[a_wr_i.addr] <= a_wr_i.data;
        end
    end

    // Synchronous reads return pre-write data on an address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            a_rdata_q <= mem_q[a_raddr_i];
            b_rdata_q <= b_en_i ? mem_q[b_raddr_i] : '0;
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/pixel_histogram_engine.sv
// 64-bin histogram of a 4096-pixel 6-bit image: clear bins, scan pixels through a
// forwarded read-modify-write pipeline, then drain and hold done.
module pixel_histogram_engine
    import pixel_hist_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              img_we,
    input  logic [ADDR_W-1:0] img_waddr,
    input  logic [PIX_W-1:0]  img_wdata,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] count,
    input  logic [PIX_W-1:0]  bin_raddr,
    output logic [BIN_W-1:0]  bin_rdata
);

    state_e            state_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] count_q;
    logic [PIX_W-1:0]  clr_idx_q;
    logic [1:0]        drain_q;

    logic [PIX_W-1:0]  img_mem_q [N_PIX];

    logic              s1_v_q;
    logic [PIX_W-1:0]  s1_pix_q;
    logic              s2_v_q;
    logic [PIX_W-1:0]  s2_pix_q;
    bin_wr_t           fwd_q;
    bin_wr_t           wr_d;
    logic [BIN_W-1:0]  a_rdata;
    logic [BIN_W-1:0]  bin_base;

    logic              start_run_c;
    logic              run_end_c;
    logic              busy_d;

    always_comb begin
        start_run_c = start && ((state_q == IDLE) || (state_q == DONE));
        run_end_c   = (state_q == DRAIN) && (drain_q == 2'(PIPE_DEPTH - 1));
        busy_d      = busy_q;
        if (start_run_c) begin
            busy_d = 1'b1;
        end else if (run_end_c) begin
            busy_d = 1'b0;
        end
    end

    // Run sequencing: IDLE/DONE -> CLEAR -> SCAN -> DRAIN -> DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
            clr_idx_q <= '0;
            drain_q   <= '0;
        end else begin
            busy_q <= busy_d;
            case (state_q)
                IDLE, DONE: begin
                    if (start_run_c) begin
                        state_q   <= CLEAR;
                        done_q    <= 1'b0;
                        clr_idx_q <= '0;
                        count_q   <= '0;
                    end
                end
                CLEAR: begin
                    clr_idx_q <= clr_idx_q + PIX_W'(1);
                    if (clr_idx_q == PIX_W'(N_BINS - 1)) begin
                        state_q <= SCAN;
                        count_q <= '0;
                    end
                end
                SCAN: begin
                    count_q <= count_q + ADDR_W'(1);
                    if (count_q == ADDR_W'(N_PIX - 1)) begin
                        state_q <= DRAIN;
                        drain_q <= '0;
                    end
                end
                DRAIN: begin
                    drain_q <= drain_q + 2'd1;
                    if (run_end_c) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The image is frozen while a run is in progress.
    always_ff @(posedge clk) begin
        if (img_we && !busy_q) begin
            img_mem_q[img_waddr] <= img_wdata;
        end
    end

    // Stage 1 holds the fetched pixel (bin read issued), stage 2 writes bin+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s1_pix_q <= '0;
            s2_v_q   <= 1'b0;
            s2_pix_q <= '0;
            fwd_q    <= '0;
        end else begin
            s1_v_q   <= (state_q == SCAN);
            s1_pix_q <= img_mem_q[count_q];
            s2_v_q   <= s1_v_q;
            s2_pix_q <= s1_pix_q;
            fwd_q    <= wr_d;
        end
    end

    // The write committed alongside this bin's read is newer than the RAM data.
    always_comb begin
        bin_base = a_rdata;
        if (fwd_q.we && (fwd_q.addr == s2_pix_q)) begin
            bin_base = fwd_q.data;
        end
        wr_d = '0;
        if (state_q == CLEAR) begin
            wr_d.we   = 1'b1;
            wr_d.addr = clr_idx_q;
            wr_d.data = '0;
        end else if (s2_v_q) begin
            wr_d.we   = 1'b1;
            wr_d.addr = s2_pix_q;
            wr_d.data = bin_base + BIN_W'(1);
        end
    end

    hist_bin_ram u_bin_ram (
        .clk       (clk),
        .rst       (rst),
        .a_wr_i    (wr_d),
        .a_raddr_i (s1_pix_q),
        .a_rdata_o (a_rdata),
        .b_en_i    (!busy_d),
        .b_raddr_i (bin_raddr),
        .b_rdata_o (bin_rdata)
    );

    assign busy  = busy_q;
    assign done  = done_q;
    assign count = count_q;

endmodule

// File: tb/tb_pixel_histogram_engine.sv
// Directed bench for pixel_histogram_engine: loads images, runs histograms, checks bins and timing.
module tb_pixel_histogram_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        img_we;
    logic [11:0] img_waddr;
    logic [5:0]  img_wdata;
    logic        start;
    logic        busy;
    logic        done;
    logic [11:0] count;
    logic [5:0]  bin_raddr;
    logic [12:0] bin_rdata;

    int n_vec = 0;
    int n_err = 0;

    logic [5:0] img_m [4096];
    int         exp_h [64];
    int         got_h [64];

    pixel_histogram_engine dut (
        .clk       (clk),
        .rst       (rst),
        .img_we    (img_we),
        .img_waddr (img_waddr),
        .img_wdata (img_wdata),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .bin_raddr (bin_raddr),
        .bin_rdata (bin_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] pix_of(input int mode, input int a);
        logic [5:0] v;
        v = 6'd0;
        case (mode)
            0: v = 6'd63;
            1: v = 6'(a % 64);
            default: begin
                case (a % 6)
                    0, 1, 3: v = 6'd5;
                    default: v = 6'd7;
                endcase
            end
        endcase
        return v;
    endfunction

    task automatic load_img(input int mode);
        for (int a = 0; a < 4096; a++) begin
            img_we    = 1'b1;
            img_waddr = 12'(a);
            img_wdata = pix_of(mode, a);
            img_m[a]  = pix_of(mode, a);
            tick();
        end
        img_we = 1'b0;
    endtask

    task automatic build_model();
        for (int b = 0; b < 64; b++) exp_h[b] = 0;
        for (int a = 0; a < 4096; a++) exp_h[int'(img_m[a])]++;
    endtask

    task automatic read_bins();
        for (int b = 0; b < 64; b++) begin
            bin_raddr = 6'(b);
            tick();
            got_h[b] = int'(bin_rdata);
        end
    endtask

    task automatic compare_bins(input string tag);
        int sum;
        sum = 0;
        for (int b = 0; b < 64; b++) begin
            chk($sformatf("%s_bin%0d", tag, b), got_h[b], exp_h[b]);
            sum += got_h[b];
        end
        chk({tag, "_sum"}, sum, 4096);
    endtask

    // Start a run; optionally inject start/img_we mid-scan, or reset at a scan address.
    task automatic do_run(input string tag, input bit inject, input int abort_at);
        int n;
        bit aborted;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_rise"}, int'(busy), 1);
        chk({tag, "_done_clr"}, int'(done), 0);
        n = 0;
        aborted = 1'b0;
        while (!done && n < 5000 && !aborted) begin
            tick();
            n++;
            start  = 1'b0;
            img_we = 1'b0;
            if (n == 32) chk({tag, "_count_clear"}, int'(count), 0);
            if (n == 1064) chk({tag, "_count_scan"}, int'(count), 1000);
            if (n == 3000) chk({tag, "_rdata_busy"}, int'(bin_rdata), 0);
            if (inject && n == 2000) begin
                start     = 1'b1;
                img_we    = 1'b1;
                img_waddr = 12'd7;
                img_wdata = 6'd33;
            end
            if (abort_at >= 0 && n == 64 + abort_at) begin
                chk({tag, "_count_abort"}, int'(count), abort_at);
                #2 rst = 1'b1;
                #1;
                chk({tag, "_rst_busy"}, int'(busy), 0);
                chk({tag, "_rst_done"}, int'(done), 0);
                chk({tag, "_rst_count"}, int'(count), 0);
                chk({tag, "_rst_rdata"}, int'(bin_rdata), 0);
                rst = 1'b0;
                aborted = 1'b1;
            end
        end
        if (!aborted) begin
            chk({tag, "_latency"}, n, 4163);
            chk({tag, "_busy_fall"}, int'(busy), 0);
            chk({tag, "_done_set"}, int'(done), 1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        img_we    = 1'b0;
        img_waddr = '0;
        img_wdata = '0;
        start     = 1'b0;
        bin_raddr = '0;
        #3;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_count", int'(count), 0);
        chk("reset_rdata", int'(bin_rdata), 0);
        #4 rst = 1'b0;
        tick();
        tick();

        // All pixels 63: every increment collides with the previous one.
        load_img(0);
        do_run("t2", 1'b0, -1);
        read_bins();
        for (int b = 0; b < 64; b++) exp_h[b] = (b == 63) ? 4096 : 0;
        compare_bins("t2");
        chk("t2_done_hold", int'(done), 1);

        // Ramp image: each bin gets exactly 64.
        load_img(1);
        do_run("t3", 1'b0, -1);
        read_bins();
        for (int b = 0; b < 64; b++) exp_h[b] = 64;
        compare_bins("t3");

        // 5,5,7,5,7,7 repeated: 682 full periods plus 5,5,7,5.
        load_img(2);
        do_run("t4", 1'b0, -1);
        read_bins();
        build_model();
        compare_bins("t4");
        chk("t4_bin5_hand", got_h[5], 2049);
        chk("t4_bin7_hand", got_h[7], 2047);

        // start and img_we during SCAN are ignored; rerun must match and start from cleared bins.
        do_run("t5a", 1'b1, -1);
        read_bins();
        compare_bins("t5a");
        do_run("t5b", 1'b0, -1);
        read_bins();
        compare_bins("t5b");
        chk("t5b_bin33", got_h[33], 0);

        // Reset partway through the scan, then a clean run.
        do_run("t6a", 1'b0, 2000);
        tick();
        chk("t6_done_after_rst", int'(done), 0);
        chk("t6_busy_after_rst", int'(busy), 0);
        load_img(1);
        do_run("t6b", 1'b0, -1);
        read_bins();
        for (int b = 0; b < 64; b++) exp_h[b] = 64;
        compare_bins("t6b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
